// File: rtl/cavlc_coeff_scanner.sv
// cavlc_coeff_scanner: serial reverse-zigzag CAVLC statistics engine for one residual block.
// Define CAVLC_ZERO_BLOCK_BYPASS_EN to send all-zero blocks straight to DONE without scanning.
module cavlc_coeff_scanner #(
  parameter int COEFF_W = 8,
  parameter int TAG_W   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [16*COEFF_W-1:0] in_coeff,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones,
  output logic [2:0]            t1_sign,
  output logic [4:0]            total_zeros,
  output logic [16*COEFF_W-1:0] level_list,
  output logic [16*4-1:0]       run_list,
  output logic [TAG_W-1:0]      out_tag
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;

  logic [15:0][COEFF_W-1:0] in_arr, coeff_q, level_q;
  logic [15:0][3:0]         run_q;
  logic [1:0]               mode_q, mode_in;
  logic [3:0]               idx, idx_init, pos, raster;
  logic                     seen, t1_open;
  logic [3:0]               zrun, zrun_nx;
  logic [4:0]               tc_q, tc_nx, tz_q;
  logic [1:0]               t1_q;
  logic [2:0]               sign_q;
  logic [TAG_W-1:0]         tag_q;
  logic [COEFF_W-1:0]       x;
  logic                     x_nz, x_abs1, accept, skip_scan;

  function automatic logic [3:0] zigzag(input logic [3:0] p);
    case (p)
      4'd0:  zigzag = 4'd0;
      4'd1:  zigzag = 4'd1;
      4'd2:  zigzag = 4'd4;
      4'd3:  zigzag = 4'd8;
      4'd4:  zigzag = 4'd5;
      4'd5:  zigzag = 4'd2;
      4'd6:  zigzag = 4'd3;
      4'd7:  zigzag = 4'd6;
      4'd8:  zigzag = 4'd9;
      4'd9:  zigzag = 4'd12;
      4'd10: zigzag = 4'd13;
      4'd11: zigzag = 4'd10;
      4'd12: zigzag = 4'd7;
      4'd13: zigzag = 4'd11;
      4'd14: zigzag = 4'd14;
      default: zigzag = 4'd15;
    endcase
  endfunction

  assign in_arr   = in_coeff;
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    mode_in = (in_mode == 2'd3) ? 2'd0 : in_mode;
    case (mode_in)
      2'd1:    idx_init = 4'd14;
      2'd2:    idx_init = 4'd3;
      default: idx_init = 4'd15;
    endcase
    pos     = (mode_q == 2'd1) ? idx + 4'd1 : idx;
    raster  = (mode_q == 2'd2) ? idx : zigzag(pos);
    x       = coeff_q[raster];
    x_nz    = |x;
    // Most-negative value differs from both 1 and all-ones, so it never counts as a trailing one.
    x_abs1  = (x == COEFF_W'(1)) || (x == '1);
    tc_nx   = tc_q + {4'd0, x_nz};
    zrun_nx = x_nz ? '0 : (seen ? zrun + 4'd1 : zrun);
  end

`ifdef CAVLC_ZERO_BLOCK_BYPASS_EN
  logic any_nz;
  always_comb begin
    any_nz = 1'b0;
    for (int unsigned i = 0; i < 16; i++)
      if ((mode_in == 2'd0) || (mode_in == 2'd1 && i != 0) || (mode_in == 2'd2 && i < 4))
        any_nz = any_nz | (|in_arr[i]);
  end
  assign skip_scan = !any_nz;
`else
  assign skip_scan = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = skip_scan ? DONE : SCAN;
      SCAN: if (idx == 4'd0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coeff_q <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
      idx     <= '0;
      seen    <= 1'b0;
      t1_open <= 1'b0;
      zrun    <= '0;
      tc_q    <= '0;
      tz_q    <= '0;
      t1_q    <= '0;
      sign_q  <= '0;
      level_q <= '0;
      run_q   <= '0;
    end else if (accept) begin
      coeff_q <= in_arr;
      mode_q  <= mode_in;
      tag_q   <= in_tag;
      idx     <= idx_init;
      seen    <= 1'b0;
      t1_open <= 1'b1;
      zrun    <= '0;
      tc_q    <= '0;
      tz_q    <= '0;
      t1_q    <= '0;
      sign_q  <= '0;
      level_q <= '0;
      run_q   <= '0;
    end else if (state == SCAN) begin
      idx  <= idx - 4'd1;
      zrun <= zrun_nx;
      tc_q <= tc_nx;
      if (x_nz) begin
        seen             <= 1'b1;
        level_q[tc_q[3:0]] <= x;
        if (tc_q != 5'd0) run_q[4'(tc_q - 5'd1)] <= zrun;
        if (t1_open && x_abs1 && t1_q != 2'd3) begin
          sign_q <= sign_q | (3'(x[COEFF_W-1]) << t1_q);
          t1_q   <= t1_q + 2'd1;
        end else begin
          t1_open <= 1'b0;
        end
      end else if (seen) begin
        tz_q <= tz_q + 5'd1;
      end
      // Last position closes the run of the lowest-frequency level; later NBA overrides the one above.
      if (idx == 4'd0 && tc_nx != 5'd0) run_q[4'(tc_nx - 5'd1)] <= zrun_nx;
    end
  end

  assign out_valid     = (state == DONE);
  assign total_coeff   = tc_q;
  assign trailing_ones = t1_q;
  assign t1_sign       = sign_q;
  assign total_zeros   = tz_q;
  assign level_list    = level_q;
  assign run_list      = run_q;
  assign out_tag       = tag_q;
endmodule

// File: tb/tb_cavlc_coeff_scanner.sv
// tb_cavlc_coeff_scanner: scoreboard bench; a frequency-ordered reference model predicts each block.
module tb_cavlc_coeff_scanner;
  localparam int CW = 8;
  localparam int TW = 20;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      in_mode;
  logic [16*CW-1:0] in_coeff, level_list;
  logic [TW-1:0]   in_tag, out_tag;
  logic [4:0]      total_coeff, total_zeros;
  logic [1:0]      trailing_ones;
  logic [2:0]      t1_sign;
  logic [63:0]     run_list;

  cavlc_coeff_scanner #(.COEFF_W(CW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_coeff(in_coeff), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones), .t1_sign(t1_sign),
    .total_zeros(total_zeros), .level_list(level_list), .run_list(run_list), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [4:0]  tc;
    logic [1:0]  t1;
    logic [2:0]  sign;
    logic [4:0]  tz;
    logic [16*CW-1:0] lvl;
    logic [63:0] run;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   zz[16]  = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int   blk[16];
  int   picks[7] = '{1, -1, 2, -2, -128, 127, 5};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int mode, input int c[16], input logic [TW-1:0] tag);
    exp_t e;
    int m, n, hp, k;
    int s[16], posn[16], lv[16];
    m = (mode == 3) ? 0 : mode;
    n = (m == 0) ? 16 : (m == 1) ? 15 : 4;
    for (int p = 0; p < n; p++)
      s[p] = (m == 0) ? c[zz[p]] : (m == 1) ? c[zz[p+1]] : c[p];
    k = 0; hp = -1;
    for (int p = n - 1; p >= 0; p--)
      if (s[p] != 0) begin
        if (hp < 0) hp = p;
        posn[k] = p; lv[k] = s[p]; k++;
      end
    e.tc = 5'(k);
    e.tz = (k > 0) ? 5'(hp + 1 - k) : 5'd0;
    e.t1 = 2'd0; e.sign = 3'd0;
    for (int j = 0; j < k && j < 3; j++) begin
      if (lv[j] != 1 && lv[j] != -1) break;
      if (lv[j] < 0) e.sign[j] = 1'b1;
      e.t1 = e.t1 + 2'd1;
    end
    e.lvl = '0; e.run = '0;
    for (int j = 0; j < k; j++) begin
      e.lvl[j*CW +: CW] = CW'(lv[j]);
      e.run[j*4 +: 4]   = (j + 1 < k) ? 4'(posn[j] - posn[j+1] - 1) : 4'(posn[j]);
    end
`ifdef CAVLC_ZERO_BLOCK_BYPASS_EN
    e.lat = (k == 0) ? 1 : n;
`else
    e.lat = n;
`endif
    e.tag = tag;
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic do_accept(input int mode, input int c[16], input logic [TW-1:0] tag);
    int waits = 0;
    in_mode = 2'(mode);
    in_tag  = tag;
    for (int i = 0; i < 16; i++) in_coeff[i*CW +: CW] = CW'(c[i]);
    in_valid = 1'b1;
    while (!in_ready && waits < 40) begin
      @(negedge clk); waits++;
    end
    check("accept_timeout", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int mode, input int c[16], input int bp);
    exp_t e;
    int lat = 0;
    logic [TW-1:0] tag;
    tag = TW'($urandom);
    sb.push_back(model(mode, c, tag));
    do_accept(mode, c, tag);
    while (lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    e = sb.pop_front();
    check("out_valid_timeout", 256'(out_valid), 256'(1));
    check("latency", 256'(lat), 256'(e.lat));
    check("total_coeff", 256'(total_coeff), 256'(e.tc));
    check("trailing_ones", 256'(trailing_ones), 256'(e.t1));
    check("t1_sign", 256'(t1_sign), 256'(e.sign));
    check("total_zeros", 256'(total_zeros), 256'(e.tz));
    check("level_list", 256'(level_list), 256'(e.lvl));
    check("run_list", 256'(run_list), 256'(e.run));
    check("out_tag", 256'(out_tag), 256'(e.tag));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_in_ready", 256'(in_ready), 256'(0));
      check("bp_level_list", 256'(level_list), 256'(e.lvl));
      check("bp_run_list", 256'(run_list), 256'(e.run));
      check("bp_total_coeff", 256'(total_coeff), 256'(e.tc));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_out_valid", 256'(out_valid), 256'(0));
    check("post_hs_in_ready", 256'(in_ready), 256'(1));
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 16; i++) blk[i] = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = '0; in_coeff = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 256'(in_ready), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_in_ready_after", 256'(in_ready), 256'(1));
    check("reset_total_coeff", 256'(total_coeff), 256'(0));
    check("reset_level_list", 256'(level_list), 256'(0));
    check("reset_run_list", 256'(run_list), 256'(0));
    check("reset_out_tag", 256'(out_tag), 256'(0));

    // Mode 0 reference block
    clear_blk();
    blk[zz[1]] = 3; blk[zz[2]] = -1; blk[zz[5]] = -1; blk[zz[6]] = 1; blk[zz[8]] = 1;
    run_block(0, blk, 0);
    // Same block presented as mode 3 (aliases mode 0)
    run_block(3, blk, 0);

    // Mode 2 chroma DC
    clear_blk();
    blk[0] = 2; blk[3] = -1;
    run_block(2, blk, 0);

    // Mode 1 AC: raster 0 is outside the scan
    clear_blk();
    blk[0] = 7; blk[15] = 1;
    run_block(1, blk, 0);

    // Four +-1 coefficients, with 5 cycles of backpressure
    clear_blk();
    blk[zz[0]] = 1; blk[zz[1]] = -1; blk[zz[2]] = 1; blk[zz[3]] = 1;
    run_block(0, blk, 5);

    // All-zero blocks in every mode; mode 1 with only a DC value is also zero
    clear_blk();
    run_block(0, blk, 0);
    run_block(2, blk, 0);
    blk[0] = -5;
    run_block(1, blk, 0);

    // Fully populated block including the most-negative value
    for (int i = 0; i < 16; i++) blk[i] = (i == 4) ? -128 : ((i % 3 == 0) ? -1 : 1);
    run_block(0, blk, 1);

    // Reset mid-scan, then the reference block must scan cleanly
    clear_blk();
    blk[zz[1]] = 3; blk[zz[2]] = -1; blk[zz[5]] = -1; blk[zz[6]] = 1; blk[zz[8]] = 1;
    do_accept(0, blk, 20'hABCDE);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready_low", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_total_coeff", 256'(total_coeff), 256'(0));
    check("rst_trailing_ones", 256'(trailing_ones), 256'(0));
    check("rst_total_zeros", 256'(total_zeros), 256'(0));
    check("rst_level_list", 256'(level_list), 256'(0));
    check("rst_run_list", 256'(run_list), 256'(0));
    check("rst_out_tag", 256'(out_tag), 256'(0));
    run_block(0, blk, 0);

    // Random sparse blocks
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 16; i++)
        blk[i] = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 6)] : 0;
      run_block(int'($urandom_range(0, 3)), blk, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
